// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : HD44780 command bytes, default timing, and FSM state type
//               for the LCD write-bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam logic [7:0] FUNCTION_SET = 8'h38;
    localparam logic [7:0] DISPLAY_OFF  = 8'h08;
    localparam logic [7:0] CLEAR        = 8'h01;
    localparam logic [7:0] ENTRY_MODE   = 8'h06;
    localparam logic [7:0] DISPLAY_ON   = 8'h0C;
    localparam logic [7:0] RETURN_HOME  = 8'h02;
    localparam logic [7:0] SET_LINE1    = 8'h80;
    localparam logic [7:0] SET_LINE2    = 8'hC0;

    localparam int unsigned T_SETUP_DEF = 10;
    localparam int unsigned T_EPW_DEF   = 50;
    localparam int unsigned T_HOLD_DEF  = 10;
    localparam int unsigned T_CMD_DEF   = 5_000;
    localparam int unsigned T_LONG_DEF  = 200_000;
    localparam int unsigned T_PWRUP_DEF = 2_000_000;

    localparam int CNT_W = 21;
    localparam logic [2:0] INIT_LAST = 3'd4;

    typedef enum logic [2:0] {
        ST_PWRUP      = 3'd0,
        ST_INIT_ISSUE = 3'd1,
        ST_SETUP      = 3'd2,
        ST_EHIGH      = 3'd3,
        ST_HOLD       = 3'd4,
        ST_WAIT       = 3'd5,
        ST_IDLE       = 3'd6
    } lcd_state_e;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = FUNCTION_SET;
            3'd1:    b = DISPLAY_OFF;
            3'd2:    b = CLEAR;
            3'd3:    b = ENTRY_MODE;
            default: b = DISPLAY_ON;
        endcase
        return b;
    endfunction

    // Clear (0x01) and both return-home encodings need the long execution wait.
    function automatic logic is_long_wait(input logic rs, input logic [7:0] d);
        return !rs && (d == CLEAR || d == RETURN_HOME || d == 8'h03);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_arbiter_if
// Description : Two-requester write-request bus plus LCD pin bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_bus_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_rs;
    logic [15:0] req_data;
    logic [1:0]  req_lock;
    logic [1:0]  req_ready;
    logic        lcd_e;
    logic        lcd_rs;
    logic        lcd_rw;
    logic [7:0]  lcd_data;
    logic        init_done;
    logic        busy;

    modport master (
        output req_valid, req_rs, req_data, req_lock,
        input  req_ready, lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, busy
    );

    modport slave (
        input  req_valid, req_rs, req_data, req_lock,
        output req_ready, lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, busy
    );
endinterface
`default_nettype wire

// File: rtl/lcd_bus_arbiter_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : lcd_rr_arb
// Description : Two-way round-robin arbiter with requester lock.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_rr_arb (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_enable,
    input  wire logic       i_idle,
    input  wire logic [1:0] i_valid,
    input  wire logic [1:0] i_lock,
    output logic      [1:0] o_grant
);

    logic r_ptr;
    logic r_locked;
    logic r_owner;
    logic w_first;
    logic w_hs;
    logic w_idx;

    always_comb begin
        o_grant = 2'b00;
        w_first = ~r_ptr;
        if (i_enable) begin
            if (r_locked) begin
                o_grant[r_owner] = i_valid[r_owner];
            end else if (i_valid[w_first]) begin
                o_grant[w_first] = 1'b1;
            end else if (i_valid[r_ptr]) begin
                o_grant[r_ptr] = 1'b1;
            end
        end
    end

    assign w_hs  = |o_grant;
    assign w_idx = o_grant[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= 1'b1;
            r_locked <= 1'b0;
            r_owner  <= 1'b0;
        end else begin
            if (w_hs) begin
                r_ptr <= w_idx;
                if (i_lock[w_idx]) begin
                    r_locked <= 1'b1;
                    r_owner  <= w_idx;
                end else if (r_locked && (r_owner == w_idx)) begin
                    r_locked <= 1'b0;
                end
            end else if (i_idle && r_locked && !i_lock[r_owner]) begin
                // Owner let go of lock without writing: release the other side.
                r_locked <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_arbiter
// Description : HD44780 write sequencer: power-up init, then arbitrated
//               single-byte writes with full E timing and execution waits.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP = T_SETUP_DEF,
    parameter int unsigned T_EPW   = T_EPW_DEF,
    parameter int unsigned T_HOLD  = T_HOLD_DEF,
    parameter int unsigned T_CMD   = T_CMD_DEF,
    parameter int unsigned T_LONG  = T_LONG_DEF,
    parameter int unsigned T_PWRUP = T_PWRUP_DEF
) (
    input wire logic          clk,
    input wire logic          rst,
    lcd_bus_arbiter_if.slave  bus
);

    lcd_state_e       r_state,     w_state_nxt;
    logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
    logic [2:0]       r_init_idx,  w_init_idx_nxt;
    logic             r_init_done, w_init_done_nxt;
    logic             r_lcd_e,     w_lcd_e_nxt;
    logic             r_lcd_rs,    w_lcd_rs_nxt;
    logic [7:0]       r_lcd_data,  w_lcd_data_nxt;

    logic [1:0] w_grant;
    logic       w_idle;
    logic       w_sel;
    logic       w_cnt_zero;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_sel      = w_grant[1];
    assign w_cnt_zero = (r_cnt == '0);

    lcd_rr_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_enable (w_idle & r_init_done),
        .i_idle   (w_idle),
        .i_valid  (bus.req_valid),
        .i_lock   (bus.req_lock),
        .o_grant  (w_grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_PWRUP;
            r_cnt       <= cnt_load(T_PWRUP);
            r_init_idx  <= 3'd0;
            r_init_done <= 1'b0;
            r_lcd_e     <= 1'b0;
            r_lcd_rs    <= 1'b0;
            r_lcd_data  <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_init_idx  <= w_init_idx_nxt;
            r_init_done <= w_init_done_nxt;
            r_lcd_e     <= w_lcd_e_nxt;
            r_lcd_rs    <= w_lcd_rs_nxt;
            r_lcd_data  <= w_lcd_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = w_cnt_zero ? r_cnt : r_cnt - CNT_W'(1);
        w_init_idx_nxt  = r_init_idx;
        w_init_done_nxt = r_init_done;
        w_lcd_e_nxt     = r_lcd_e;
        w_lcd_rs_nxt    = r_lcd_rs;
        w_lcd_data_nxt  = r_lcd_data;

        unique case (r_state)
            ST_PWRUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt    = ST_INIT_ISSUE;
                    w_init_idx_nxt = 3'd0;
                end
            end
            ST_INIT_ISSUE: begin
                w_lcd_rs_nxt   = 1'b0;
                w_lcd_data_nxt = init_byte(r_init_idx);
                w_state_nxt    = ST_SETUP;
                w_cnt_nxt      = cnt_load(T_SETUP);
            end
            ST_SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_EHIGH;
                    w_lcd_e_nxt = 1'b1;
                    w_cnt_nxt   = cnt_load(T_EPW);
                end
            end
            ST_EHIGH: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_HOLD;
                    w_lcd_e_nxt = 1'b0;
                    w_cnt_nxt   = cnt_load(T_HOLD);
                end
            end
            ST_HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = is_long_wait(r_lcd_rs, r_lcd_data) ? cnt_load(T_LONG)
                                                                       : cnt_load(T_CMD);
                end
            end
            ST_WAIT: begin
                if (w_cnt_zero) begin
                    if (!r_init_done && (r_init_idx != INIT_LAST)) begin
                        w_init_idx_nxt = r_init_idx + 3'd1;
                        w_state_nxt    = ST_INIT_ISSUE;
                    end else begin
                        w_init_done_nxt = 1'b1;
                        w_state_nxt     = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (|w_grant) begin
                    w_lcd_rs_nxt   = bus.req_rs[w_sel];
                    w_lcd_data_nxt = w_sel ? bus.req_data[15:8] : bus.req_data[7:0];
                    w_state_nxt    = ST_SETUP;
                    w_cnt_nxt      = cnt_load(T_SETUP);
                end
            end
            default: begin
                w_state_nxt = ST_PWRUP;
                w_cnt_nxt   = cnt_load(T_PWRUP);
            end
        endcase
    end

    assign bus.req_ready = w_grant;
    assign bus.lcd_e     = r_lcd_e;
    assign bus.lcd_rs    = r_lcd_rs;
    assign bus.lcd_rw    = 1'b0;
    assign bus.lcd_data  = r_lcd_data;
    assign bus.init_done = r_init_done;
    assign bus.busy      = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_bus_arbiter
// Description : Randomized self-checking bench with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_bus_arbiter;

    localparam int TS = 2, TE = 4, TH = 2, TC = 8, TL = 20, TP = 30;
    localparam int BASE = 1 + TS + TE + TH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lcd_bus_arbiter_if bus ();

    lcd_bus_arbiter #(
        .T_SETUP(TS), .T_EPW(TE), .T_HOLD(TH),
        .T_CMD(TC), .T_LONG(TL), .T_PWRUP(TP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic rs; logic [7:0] data; logic lock; } wr_t;
    typedef struct packed { int rise; logic rs; logic [7:0] data; } pulse_t;

    wr_t        src0[$];
    wr_t        src1[$];
    pulse_t     exp_q[$];
    int         rise_log[$];
    logic [7:0] obs_log[$];

    int     n_vec = 0, n_err = 0, cyc = 0, n_pulses = 0, gap_pct = 0;
    int     m_next_idle = 0, m_done = 0, m_ptr = 1, m_owner = 0;
    bit     m_locked = 1'b0, prev_e = 1'b0;
    pulse_t cur;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int wait_len(input logic rs, input logic [7:0] d);
        return (!rs && (d inside {8'h01, 8'h02, 8'h03})) ? TL : TC;
    endfunction

    task automatic model_reset();
        logic [7:0] seq [5];
        int t;
        seq = '{8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
        cyc = 0; m_ptr = 1; m_locked = 1'b0; m_owner = 0; prev_e = 1'b0;
        exp_q.delete(); rise_log.delete(); obs_log.delete(); n_pulses = 0;
        t = TP;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back('{t + 1 + TS, 1'b0, seq[k]});
            t += BASE + wait_len(1'b0, seq[k]);
        end
        m_done = t;
        m_next_idle = t;
    endtask

    task automatic tick();
        logic [1:0] v, lk, exp_ready;
        wr_t h0, h1, w;
        bit idle;
        int sel, first;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.lcd_e && !prev_e) begin
            n_pulses++;
            rise_log.push_back(cyc);
            obs_log.push_back(bus.lcd_data);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_e", 32'd1, 32'd0);
            end else begin
                cur = exp_q.pop_front();
                check_eq("e_rise_cycle", cyc, cur.rise);
                check_eq("e_rs", {31'd0, bus.lcd_rs}, {31'd0, cur.rs});
                check_eq("e_data", {24'd0, bus.lcd_data}, {24'd0, cur.data});
                check_eq("lcd_rw", {31'd0, bus.lcd_rw}, 32'd0);
            end
        end
        if (!bus.lcd_e && prev_e) begin
            check_eq("e_width", cyc - rise_log[$], TE);
            check_eq("hold_bus", {23'd0, bus.lcd_rs, bus.lcd_data}, {23'd0, cur.rs, cur.data});
        end
        prev_e = bus.lcd_e;
        check_eq("init_done", {31'd0, bus.init_done}, {31'd0, cyc >= m_done});
        check_eq("busy", {31'd0, bus.busy}, {31'd0, cyc < m_next_idle});

        v = 2'b00;
        h0 = '{rs: 1'($urandom_range(1)), data: 8'($urandom_range(255)), lock: 1'b0};
        h1 = '{rs: 1'($urandom_range(1)), data: 8'($urandom_range(255)), lock: 1'b0};
        if (src0.size() > 0 && $urandom_range(99) >= gap_pct) begin v[0] = 1'b1; h0 = src0[0]; end
        if (src1.size() > 0 && $urandom_range(99) >= gap_pct) begin v[1] = 1'b1; h1 = src1[0]; end
        lk = {v[1] & h1.lock, v[0] & h0.lock};
        bus.req_valid = v;
        bus.req_rs    = {h1.rs, h0.rs};
        bus.req_data  = {h1.data, h0.data};
        bus.req_lock  = lk;
        #1;

        idle = (cyc >= m_next_idle);
        exp_ready = 2'b00;
        if (idle) begin
            first = 1 - m_ptr;
            if (m_locked)      exp_ready[m_owner] = v[m_owner];
            else if (v[first]) exp_ready[first] = 1'b1;
            else if (v[m_ptr]) exp_ready[m_ptr] = 1'b1;
        end
        check_eq("req_ready", {30'd0, bus.req_ready}, {30'd0, exp_ready});
        if (exp_ready != 2'b00) begin
            sel = exp_ready[1] ? 1 : 0;
            w = (sel == 1) ? src1.pop_front() : src0.pop_front();
            exp_q.push_back('{cyc + 1 + TS, w.rs, w.data});
            m_next_idle = cyc + BASE + wait_len(w.rs, w.data);
            m_ptr = sel;
            if (lk[sel]) begin
                m_locked = 1'b1;
                m_owner  = sel;
            end else if (m_locked && m_owner == sel) begin
                m_locked = 1'b0;
            end
        end
        if (idle && m_locked && !lk[m_owner]) m_locked = 1'b0;
    endtask

    task automatic run_quiet(input int budget);
        int n = 0;
        while ((src0.size() > 0 || src1.size() > 0 || exp_q.size() > 0 || cyc < m_next_idle)
               && n < budget) begin
            tick();
            n++;
        end
        check_eq("drain_timeout", {31'd0, n < budget}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int i_first, i_last, n;
        bus.req_valid = '0; bus.req_rs = '0; bus.req_data = '0; bus.req_lock = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_lcd_e",     {31'd0, bus.lcd_e},     32'd0);
        check_eq("rst_lcd_rs",    {31'd0, bus.lcd_rs},    32'd0);
        check_eq("rst_lcd_data",  {24'd0, bus.lcd_data},  32'd0);
        check_eq("rst_lcd_rw",    {31'd0, bus.lcd_rw},    32'd0);
        check_eq("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
        check_eq("rst_init_done", {31'd0, bus.init_done}, 32'd0);
        check_eq("rst_busy",      {31'd0, bus.busy},      32'd1);
        rst = 1'b0;
        model_reset();
        run_quiet(400);
        check_eq("init_pulses", n_pulses, 5);
        check_eq("init_gap_after_clear", rise_log[3] - rise_log[2], BASE + TL);
        check_eq("init_gap_normal", rise_log[1] - rise_log[0], BASE + TC);

        // Single data write from requester 0
        rise_log.delete(); obs_log.delete();
        src0.push_back('{1'b1, 8'h41, 1'b0});
        n = cyc + 1;
        run_quiet(100);
        check_eq("d1_rise_offset", rise_log.size() > 0 ? rise_log[0] - n : -1, 1 + TS);

        // Both requesters valid, no lock: strict alternation
        obs_log.delete();
        for (int k = 0; k < 4; k++) begin
            src0.push_back('{1'b1, 8'hA0 + 8'(k), 1'b0});
            src1.push_back('{1'b1, 8'hB0 + 8'(k), 1'b0});
        end
        run_quiet(400);
        for (int k = 1; k < obs_log.size(); k++)
            check_eq("d2_alternate", {31'd0, obs_log[k][7:4] != obs_log[k-1][7:4]}, 32'd1);

        // Requester 1 locked burst while requester 0 waits
        obs_log.delete();
        src1.push_back('{1'b0, 8'hC0, 1'b1});
        for (int k = 0; k < 16; k++) src1.push_back('{1'b1, 8'h20 + 8'(k), 1'b1});
        src1.push_back('{1'b1, 8'h30, 1'b0});
        for (int k = 0; k < 3; k++) src0.push_back('{1'b1, 8'h50 + 8'(k), 1'b0});
        run_quiet(1200);
        i_first = -100; i_last = -1;
        for (int k = 0; k < obs_log.size(); k++) begin
            if (obs_log[k] == 8'hC0) i_first = k;
            if (obs_log[k] == 8'h30) i_last = k;
        end
        check_eq("d3_lock_contiguous", i_last - i_first, 17);

        // Return-home command vs the same byte as data
        rise_log.delete();
        src0.push_back('{1'b0, 8'h02, 1'b0});
        src0.push_back('{1'b1, 8'h02, 1'b0});
        src0.push_back('{1'b1, 8'h41, 1'b0});
        run_quiet(200);
        check_eq("d4_home_wait", rise_log.size() > 2 ? rise_log[1] - rise_log[0] : -1, BASE + TL);
        check_eq("d4_data02_wait", rise_log.size() > 2 ? rise_log[2] - rise_log[1] : -1, BASE + TC);

        // Randomized traffic with valid gaps and random locks
        gap_pct = 25;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(9) == 0) begin
                wr_t r;
                r.rs   = 1'($urandom_range(1));
                r.data = ($urandom_range(3) == 0) ? 8'($urandom_range(3, 1)) : 8'($urandom_range(255));
                r.lock = ($urandom_range(4) == 0);
                if ($urandom_range(1) == 0) begin
                    if (src0.size() < 3) src0.push_back(r);
                end else begin
                    if (src1.size() < 3) src1.push_back(r);
                end
            end
            tick();
        end
        run_quiet(1500);
        gap_pct = 0;

        // Reset in the middle of the E pulse
        src0.push_back('{1'b1, 8'h55, 1'b0});
        n = 0;
        while (!bus.lcd_e && n < 60) begin
            tick();
            n++;
        end
        check_eq("d5_reach_ehigh", {31'd0, bus.lcd_e}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("d5_async_e",     {31'd0, bus.lcd_e},     32'd0);
        check_eq("d5_init_done",   {31'd0, bus.init_done}, 32'd0);
        check_eq("d5_busy",        {31'd0, bus.busy},      32'd1);
        check_eq("d5_req_ready",   {30'd0, bus.req_ready}, 32'd0);
        src0.delete(); src1.delete();
        bus.req_valid = '0; bus.req_lock = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        run_quiet(400);
        check_eq("d5_reinit_pulses", n_pulses, 5);

        // Fresh pointer: requester 0 wins a simultaneous first request
        obs_log.delete();
        src0.push_back('{1'b1, 8'h60, 1'b0});
        src1.push_back('{1'b1, 8'h70, 1'b0});
        run_quiet(200);
        check_eq("rr_reset_ptr", obs_log.size() > 0 ? {24'd0, obs_log[0]} : 32'hFFFF, 32'h60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
